// File: rtl/crossbar_master_bridge.sv
// Per-master crossbar front end: queues core requests, arbitrates via request/grant,
// issues one single-beat TileLink-UL A transaction and returns the D response to the core.
module crossbar_master_bridge #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_valid,
  output logic                cpu_ready,
  input  logic                cpu_write,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wmask,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                request,
  input  logic                grant,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [2:0]          a_opcode,
  output logic [ADDR_W-1:0]   a_address,
  output logic [DATA_W-1:0]   a_data,
  output logic [DATA_W/8-1:0] a_mask,
  input  logic                d_valid,
  output logic                d_ready,
  input  logic [DATA_W-1:0]   d_data,
  input  logic                d_denied
);

  localparam int MW = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;

  typedef enum logic [2:0] {IDLE, REQ, ISSUE, RESP, RELEASE} state_t;
  state_t state;

  logic              mem_write [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [MW-1:0]     mem_mask  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] timer;
  logic          cur_write;
  logic          full, empty, push, pop, timed_out, resp_done;
  logic [2:0]    head_op;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cpu_ready = !full;
  assign push      = cpu_valid && !full;
  assign timed_out = (timer == LAST_CNT);
  assign resp_done = (state == RESP) && (d_valid || timed_out);
  assign pop       = resp_done;
  assign head_op   = !mem_write[rd_ptr] ? OP_GET :
                     (&mem_mask[rd_ptr]) ? OP_PUT_FULL : OP_PUT_PART;

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_write[wr_ptr] <= cpu_write;
      mem_addr[wr_ptr]  <= cpu_addr;
      mem_data[wr_ptr]  <= cpu_wdata;
      mem_mask[wr_ptr]  <= cpu_wmask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The head entry is popped as RESP hands over to RELEASE, so a withdrawn grant retries it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      request   <= 1'b0;
      a_valid   <= 1'b0;
      a_opcode  <= '0;
      a_address <= '0;
      a_data    <= '0;
      a_mask    <= '0;
      d_ready   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      timer     <= '0;
      cur_write <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            state   <= REQ;
            request <= 1'b1;
          end
        end
        REQ: begin
          if (grant) begin
            state     <= ISSUE;
            a_valid   <= 1'b1;
            a_opcode  <= head_op;
            a_address <= mem_addr[rd_ptr];
            a_data    <= mem_data[rd_ptr];
            a_mask    <= mem_mask[rd_ptr];
            cur_write <= mem_write[rd_ptr];
          end
        end
        ISSUE: begin
          if (a_ready) begin
            state   <= RESP;
            a_valid <= 1'b0;
            d_ready <= 1'b1;
            timer   <= '0;
          end else if (!grant) begin
            state   <= REQ;
            a_valid <= 1'b0;
          end
        end
        RESP: begin
          timer <= timer + 1'b1;
          if (d_valid) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= cur_write ? '0 : d_data;
            rsp_error <= d_denied;
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
          end
          if (resp_done) begin
            state   <= RELEASE;
            request <= 1'b0;
            d_ready <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_master_bridge.sv
// Self-checking bench for crossbar_master_bridge: scenario tasks driving the core and
// crossbar sides, with expectations taken from a queue of outstanding core requests.
module tb_crossbar_master_bridge;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MW  = 8;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_valid = 1'b0;
  logic          cpu_ready;
  logic          cpu_write = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [MW-1:0] cpu_wmask = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          request;
  logic          grant = 1'b0;
  logic          a_valid;
  logic          a_ready = 1'b0;
  logic [2:0]    a_opcode;
  logic [AW-1:0] a_address;
  logic [DW-1:0] a_data;
  logic [MW-1:0] a_mask;
  logic          d_valid = 1'b0;
  logic          d_ready;
  logic [DW-1:0] d_data = '0;
  logic          d_denied = 1'b0;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } req_t;

  req_t model_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   req_rises = 0;
  int   rsp_count = 0;
  logic prev_req = 1'b0;
  int   last_rsp_cyc = 0;
  int   push_cyc = 0;

  crossbar_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .request(request), .grant(grant),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_address(a_address), .a_data(a_data), .a_mask(a_mask),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_denied(d_denied)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_req <= request;
    if (request && !prev_req) req_rises <= req_rises + 1;
    if (rsp_valid) rsp_count <= rsp_count + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_opcode(input req_t r);
    if (!r.write) return 3'd4;
    return (r.mask == 8'hFF) ? 3'd0 : 3'd1;
  endfunction

  task automatic push_req(input logic w, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [MW-1:0] mask);
    req_t r;
    int n = 0;
    cpu_valid = 1'b1;
    cpu_write = w;
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wmask = mask;
    while (cpu_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (cpu_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_wait: cpu_ready=%b expected 1", cpu_ready);
      cpu_valid = 1'b0;
      return;
    end
    push_cyc = cyc;
    tick();
    cpu_valid = 1'b0;
    r.write = w; r.addr = addr; r.data = data; r.mask = mask;
    model_q.push_back(r);
  endtask

  task automatic serve_one(input int gdly, input int rdly, input int ddly,
                           input logic [DW-1:0] dd, input logic den,
                           input bit tmo, input bit wd);
    req_t h;
    logic [2:0] eop;
    logic [DW-1:0] erd;
    logic eerr;
    int n;
    h = model_q[0];
    eop = exp_opcode(h);
    n = 0;
    while (request !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (request !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_wait: request=%b expected 1", request);
      return;
    end
    for (int i = 0; i < gdly; i++) tick();
    checks++;
    if (a_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL a_valid_pre_grant: got %b expected 0", a_valid);
    end
    grant = 1'b1;
    tick();
    checks++;
    if (a_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL a_valid_rise: got %b expected 1", a_valid);
    end
    checks++;
    if (a_opcode !== eop) begin
      errors++;
      $display("[TB] FAIL a_opcode: got %0d expected %0d", a_opcode, eop);
    end
    checks++;
    if ({a_address, a_data, a_mask} !== {h.addr, h.data, h.mask}) begin
      errors++;
      $display("[TB] FAIL a_fields: got addr=%h data=%h mask=%h expected addr=%h data=%h mask=%h",
               a_address, a_data, a_mask, h.addr, h.data, h.mask);
    end
    if (wd) begin
      grant = 1'b0;
      tick();
      checks++;
      if (a_valid !== 1'b0 || request !== 1'b1) begin
        errors++;
        $display("[TB] FAIL withdraw_drop: got a_valid=%b request=%b expected 0 and 1", a_valid, request);
      end
      tick();
      grant = 1'b1;
      tick();
      checks++;
      if (a_valid !== 1'b1 || {a_opcode, a_address, a_data, a_mask} !== {eop, h.addr, h.data, h.mask}) begin
        errors++;
        $display("[TB] FAIL reissue: got valid=%b addr=%h data=%h expected valid=1 addr=%h data=%h",
                 a_valid, a_address, a_data, h.addr, h.data);
      end
    end
    for (int i = 0; i < rdly; i++) tick();
    checks++;
    if (a_valid !== 1'b1 || a_address !== h.addr || a_data !== h.data) begin
      errors++;
      $display("[TB] FAIL a_hold: got valid=%b addr=%h expected valid=1 addr=%h", a_valid, a_address, h.addr);
    end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checks++;
    if (d_ready !== 1'b1 || a_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resp_enter: got d_ready=%b a_valid=%b expected 1 and 0", d_ready, a_valid);
    end
    if (tmo) begin
      n = 0;
      while (d_ready === 1'b1 && n < 50) begin
        n++;
        tick();
      end
      checks++;
      if (n != TMO) begin
        errors++;
        $display("[TB] FAIL timeout_cycles: got %0d expected %0d", n, TMO);
      end
      erd  = '0;
      eerr = 1'b1;
    end else begin
      for (int i = 0; i < ddly; i++) tick();
      d_valid  = 1'b1;
      d_data   = dd;
      d_denied = den;
      tick();
      d_valid  = 1'b0;
      d_denied = 1'b0;
      d_data   = '0;
      erd  = h.write ? '0 : dd;
      eerr = den;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== erd || rsp_error !== eerr) begin
      errors++;
      $display("[TB] FAIL response: got valid=%b rdata=%h error=%b expected valid=1 rdata=%h error=%b",
               rsp_valid, rsp_rdata, rsp_error, erd, eerr);
    end
    checks++;
    if (request !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release: got request=%b d_ready=%b expected 0 and 0", request, d_ready);
    end
    last_rsp_cyc = cyc;
    h = model_q.pop_front();
    grant = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || request !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pulse_gap: got rsp_valid=%b request=%b expected 0 and 0", rsp_valid, request);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || request !== 1'b0 || a_valid !== 1'b0 || d_ready !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got cpu_ready=%b request=%b a_valid=%b d_ready=%b rsp_valid=%b expected 1 0 0 0 0",
               cpu_ready, request, a_valid, d_ready, rsp_valid);
    end
    checks++;
    if (a_opcode !== 3'd0 || a_address !== '0 || a_data !== '0 || a_mask !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got opcode=%0d addr=%h data=%h rdata=%h expected all 0",
               a_opcode, a_address, a_data, rsp_rdata);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    push_req(1'b0, 64'h0000_0000_8000_0040, 64'h1111_2222_3333_4444, 8'hFF);
    serve_one(3, 0, 2, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_writes();
    int r0;
    r0 = req_rises;
    push_req(1'b1, 64'h0000_0000_1000_0008, 64'hA5A5_5A5A_0123_4567, 8'hFF);
    push_req(1'b1, 64'h0000_0000_1000_0010, 64'h89AB_CDEF_FEDC_BA98, 8'h0F);
    serve_one(1, 1, 1, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, 1'b0);
    serve_one(0, 0, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (req_rises - r0 != 2) begin
      errors++;
      $display("[TB] FAIL write_req_pulses: got %0d expected 2", req_rises - r0);
    end
  endtask

  task automatic test_fifo_full();
    push_req(1'b0, 64'h0000_0000_2000_0000, 64'h0, 8'hFF);
    push_req(1'b1, 64'h0000_0000_2000_0008, 64'h0000_0000_0000_00AA, 8'h01);
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fifo_full_ready: got %b expected 0", cpu_ready);
    end
    fork
      push_req(1'b0, 64'h0000_0000_2000_0010, 64'h0, 8'hF0);
      serve_one(2, 0, 1, 64'h0BAD_F00D_0000_0001, 1'b0, 1'b0, 1'b0);
    join
    checks++;
    if (push_cyc < last_rsp_cyc) begin
      errors++;
      $display("[TB] FAIL fifo_third_accept: accepted in cycle %0d expected at or after %0d", push_cyc, last_rsp_cyc);
    end
    serve_one(0, 0, 0, 64'h0, 1'b1, 1'b0, 1'b0);
    serve_one(1, 0, 0, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_grant_withdraw();
    int c0;
    c0 = rsp_count;
    push_req(1'b1, 64'h0000_0000_3000_0020, 64'hCAFE_BABE_DEAD_0001, 8'h3C);
    serve_one(1, 1, 1, 64'h0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (rsp_count - c0 != 1) begin
      errors++;
      $display("[TB] FAIL withdraw_rsp_count: got %0d expected 1", rsp_count - c0);
    end
  endtask

  task automatic test_timeout();
    push_req(1'b0, 64'h0000_0000_4000_0000, 64'h0, 8'hFF);
    push_req(1'b0, 64'h0000_0000_4000_0008, 64'h0, 8'hFF);
    serve_one(0, 0, 0, 64'h0, 1'b0, 1'b1, 1'b0);
    serve_one(0, 0, 1, 64'h7777_8888_9999_AAAA, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_late_grant();
    grant   = 1'b1;
    d_valid = 1'b1;
    d_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (request !== 1'b0 || a_valid !== 1'b0 || rsp_valid !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_grant: got request=%b a_valid=%b rsp_valid=%b d_ready=%b expected all 0",
               request, a_valid, rsp_valid, d_ready);
    end
    grant   = 1'b0;
    d_valid = 1'b0;
    d_data  = '0;
    tick();
  endtask

  task automatic test_random();
    int k;
    logic w;
    logic [MW-1:0] m;
    for (int it = 0; it < 16; it++) begin
      k = $urandom_range(1, 2);
      for (int j = 0; j < k; j++) begin
        w = $urandom_range(0, 1);
        m = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        push_req(w, {$urandom, $urandom}, {$urandom, $urandom}, m);
      end
      for (int j = 0; j < k; j++)
        serve_one($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 5),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    push_req(1'b0, 64'h0000_0000_5000_0000, 64'h0, 8'hFF);
    push_req(1'b0, 64'h0000_0000_5000_0008, 64'h0, 8'hFF);
    while (request !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    grant = 1'b1;
    tick();
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checks++;
    if (d_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_setup: d_ready=%b expected 1", d_ready);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (request !== 1'b0 || a_valid !== 1'b0 || d_ready !== 1'b0 || rsp_valid !== 1'b0 || cpu_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_outputs: got request=%b a_valid=%b d_ready=%b rsp_valid=%b cpu_ready=%b expected 0 0 0 0 1",
               request, a_valid, d_ready, rsp_valid, cpu_ready);
    end
    grant = 1'b0;
    model_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (request !== 1'b0 || cpu_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_empty: got request=%b cpu_ready=%b rsp_valid=%b expected 0 1 0",
               request, cpu_ready, rsp_valid);
    end
    push_req(1'b1, 64'h0000_0000_6000_0000, 64'h0102_0304_0506_0708, 8'hFF);
    serve_one(0, 0, 0, 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_writes();
    test_fifo_full();
    test_grant_withdraw();
    test_timeout();
    test_late_grant();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
